// File: rtl/sseg_scanner_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// sseg_scanner_pkg
//   Shared constants for the 7-segment display stage: active-low glyph codes
//   in {g,f,e,d,c,b,a} order and the digit-slot index assignments.
//   The optional over-range blink (SSEG_OVERRANGE_BLINK_EN) needs nothing here.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
package sseg_scanner_pkg;

    // Glyph codes, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_GLYPH_0     = 7'b1000000;
    localparam logic [6:0] c_GLYPH_1     = 7'b1111001;
    localparam logic [6:0] c_GLYPH_2     = 7'b0100100;
    localparam logic [6:0] c_GLYPH_3     = 7'b0110000;
    localparam logic [6:0] c_GLYPH_4     = 7'b0011001;
    localparam logic [6:0] c_GLYPH_5     = 7'b0010010;
    localparam logic [6:0] c_GLYPH_6     = 7'b0000010;
    localparam logic [6:0] c_GLYPH_7     = 7'b1111000;
    localparam logic [6:0] c_GLYPH_8     = 7'b0000000;
    localparam logic [6:0] c_GLYPH_9     = 7'b0010000;
    localparam logic [6:0] c_GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] c_GLYPH_BLANK = 7'b1111111;

    // Digit-slot indices; slot index n drives anode_n[n]
    localparam logic [1:0] c_D_INT  = 2'd0;   // integer digit, decimal point lit
    localparam logic [1:0] c_D_F1   = 2'd1;   // first fractional digit
    localparam logic [1:0] c_D_F2   = 2'd2;   // second fractional digit
    localparam logic [1:0] c_D_UNIT = 2'd3;   // always blank

endpackage : sseg_scanner_pkg
`default_nettype wire

// File: rtl/sseg_decoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// sseg_decoder
//   Combinational BCD to active-low 7-segment glyph. Codes 10..15 are not
//   valid BCD and show a dash so a corrupted digit is visible on the board.
//   Ports:
//     bcd    in  4  BCD digit
//     seg_n  out 7  {g,f,e,d,c,b,a}, active-low
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
module sseg_decoder
    import sseg_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = c_GLYPH_DASH;
        case (bcd)
            4'd0:    seg_n = c_GLYPH_0;
            4'd1:    seg_n = c_GLYPH_1;
            4'd2:    seg_n = c_GLYPH_2;
            4'd3:    seg_n = c_GLYPH_3;
            4'd4:    seg_n = c_GLYPH_4;
            4'd5:    seg_n = c_GLYPH_5;
            4'd6:    seg_n = c_GLYPH_6;
            4'd7:    seg_n = c_GLYPH_7;
            4'd8:    seg_n = c_GLYPH_8;
            4'd9:    seg_n = c_GLYPH_9;
            default: seg_n = c_GLYPH_DASH;
        endcase
    end

endmodule : sseg_decoder
`default_nettype wire

// File: rtl/sseg_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// sseg_scanner
//   Display stage of the voltage path. Generates the periodic update pulse
//   (flag) for the voltage calculator, captures its three BCD digits two
//   cycles after each pulse, and multiplexes them onto a 4-digit common-anode
//   7-segment display (d0 = integer with DP, d1/d2 = fraction, d3 = blank).
//   Optional feature macro: SSEG_OVERRANGE_BLINK_EN -- blinks the display at
//   the flag rate while the captured value is 5.00 (calculator saturation).
//   Ports:
//     clk           in   1  system clock
//     rst           in   1  synchronous reset, active-high
//     integer_data  in   4  BCD integer digit
//     float1_data   in   4  BCD first fractional digit
//     float2_data   in   4  BCD second fractional digit
//     flag          out  1  one-cycle update pulse
//     anode_n       out  4  digit enables, active-low, bit0 = d0
//     seg_n         out  7  {g,f,e,d,c,b,a}, active-low
//     dp_n          out  1  decimal point, active-low
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
module sseg_scanner
    import sseg_scanner_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int UPDATE_HZ = 2,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] integer_data,
    input  logic [3:0] float1_data,
    input  logic [3:0] float2_data,
    output logic       flag,
    output logic [3:0] anode_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int c_UPDATE_DIV = CLK_HZ / UPDATE_HZ;
    localparam int c_SLOT_DIV   = CLK_HZ / SCAN_HZ;
    localparam int c_UPD_W      = $clog2(c_UPDATE_DIV);
    localparam int c_SLOT_W     = $clog2(c_SLOT_DIV);

    localparam logic [c_UPD_W-1:0]  c_UPD_LAST  = c_UPD_W'(c_UPDATE_DIV - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(c_SLOT_DIV - 1);
    localparam logic [c_SLOT_W-1:0] c_BLANK     = c_SLOT_W'(BLANK_CYC);

    //--------------------------------------------------------------------------
    // Update prescaler and flag
    //--------------------------------------------------------------------------
    logic [c_UPD_W-1:0] r_upd_cnt;
    logic               w_flag;

    assign w_flag = (r_upd_cnt == c_UPD_LAST);
    assign flag   = w_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_cnt <= '0;
        end else if (w_flag) begin
            r_upd_cnt <= '0;
        end else begin
            r_upd_cnt <= r_upd_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Capture: the calculator registers on the flag cycle, so its outputs are
    // settled by the second cycle after flag; load the shadow copy then.
    //--------------------------------------------------------------------------
    logic       r_flag_d1;
    logic       r_flag_d2;
    logic [3:0] r_sh_int;
    logic [3:0] r_sh_f1;
    logic [3:0] r_sh_f2;
    logic [3:0] w_sh_int_nxt;
    logic [3:0] w_sh_f1_nxt;
    logic [3:0] w_sh_f2_nxt;

    assign w_sh_int_nxt = r_flag_d2 ? integer_data : r_sh_int;
    assign w_sh_f1_nxt  = r_flag_d2 ? float1_data  : r_sh_f1;
    assign w_sh_f2_nxt  = r_flag_d2 ? float2_data  : r_sh_f2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_d1 <= 1'b0;
            r_flag_d2 <= 1'b0;
            r_sh_int  <= '0;
            r_sh_f1   <= '0;
            r_sh_f2   <= '0;
        end else begin
            r_flag_d1 <= w_flag;
            r_flag_d2 <= r_flag_d1;
            r_sh_int  <= w_sh_int_nxt;
            r_sh_f1   <= w_sh_f1_nxt;
            r_sh_f2   <= w_sh_f2_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Scan counter and slot index
    //--------------------------------------------------------------------------
    logic [c_SLOT_W-1:0] r_slot_cnt;
    logic [1:0]          r_idx;
    logic                w_slot_wrap;
    logic [c_SLOT_W-1:0] w_slot_nxt;
    logic [1:0]          w_idx_nxt;
    logic                w_blank_nxt;

    assign w_slot_wrap = (r_slot_cnt == c_SLOT_LAST);
    assign w_slot_nxt  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    assign w_idx_nxt   = w_slot_wrap ? r_idx + 2'd1 : r_idx;
    assign w_blank_nxt = (w_slot_nxt < c_BLANK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_idx      <= c_D_INT;
        end else begin
            r_slot_cnt <= w_slot_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Output mux. Everything is computed from next-state values so the
    // registered outputs line up with the counter/shadow they belong to;
    // this also makes a slot change coinciding with a shadow load show the
    // freshly captured digit.
    //--------------------------------------------------------------------------
    logic [3:0] w_digit;
    logic [6:0] w_glyph;
    logic [6:0] w_seg_nxt;
    logic       w_dp_nxt;
    logic       w_dark_nxt;

    always_comb begin
        w_digit = 4'd0;
        case (w_idx_nxt)
            c_D_INT: w_digit = w_sh_int_nxt;
            c_D_F1:  w_digit = w_sh_f1_nxt;
            c_D_F2:  w_digit = w_sh_f2_nxt;
            default: w_digit = 4'd0;
        endcase
    end

    sseg_decoder u_decoder (
        .bcd   (w_digit),
        .seg_n (w_glyph)
    );

    assign w_seg_nxt = (w_idx_nxt == c_D_UNIT) ? c_GLYPH_BLANK : w_glyph;
    assign w_dp_nxt  = (w_idx_nxt != c_D_INT);

`ifdef SSEG_OVERRANGE_BLINK_EN
    // Toggle only runs while the captured value is exactly 5.00; any other
    // value clears it so the display returns to steady immediately.
    logic r_blink;
    logic w_blink_nxt;
    logic w_at_sat;

    assign w_at_sat    = ({w_sh_int_nxt, w_sh_f1_nxt, w_sh_f2_nxt} == 12'h500);
    assign w_blink_nxt = !w_at_sat ? 1'b0 : (w_flag ? ~r_blink : r_blink);
    assign w_dark_nxt  = w_blank_nxt | w_blink_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink <= 1'b0;
        end else begin
            r_blink <= w_blink_nxt;
        end
    end
`else
    assign w_dark_nxt = w_blank_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_n <= 4'b1111;
            seg_n   <= c_GLYPH_BLANK;
            dp_n    <= 1'b1;
        end else begin
            anode_n <= w_dark_nxt ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
            seg_n   <= w_seg_nxt;
            dp_n    <= w_dp_nxt;
        end
    end

endmodule : sseg_scanner
`default_nettype wire

// File: tb/tb_sseg_scanner.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_sseg_scanner
//   Self-checking bench for sseg_scanner with small timing parameters.
//   The reference model tracks elapsed cycles since reset and derives the
//   expected flag, capture and scan position with plain modular arithmetic.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
module tb_sseg_scanner;

    localparam int CLK_HZ    = 1000;
    localparam int UPDATE_HZ = 2;
    localparam int SCAN_HZ   = 100;
    localparam int BLANK_CYC = 2;
    localparam int UDIV      = CLK_HZ / UPDATE_HZ;   // 500
    localparam int SDIV      = CLK_HZ / SCAN_HZ;     // 10

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] integer_data = 4'd0;
    logic [3:0] float1_data  = 4'd0;
    logic [3:0] float2_data  = 4'd0;
    logic       flag;
    logic [3:0] anode_n;
    logic [6:0] seg_n;
    logic       dp_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: cycles since reset release, shadow digits, blink
    int mn = 0;
    int sh_i = 0, sh_f1 = 0, sh_f2 = 0;
    bit mblink = 1'b0;

    always #5 clk = ~clk;

    sseg_scanner #(
        .CLK_HZ    (CLK_HZ),
        .UPDATE_HZ (UPDATE_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .integer_data (integer_data),
        .float1_data  (float1_data),
        .float2_data  (float2_data),
        .flag         (flag),
        .anode_n      (anode_n),
        .seg_n        (seg_n),
        .dp_n         (dp_n)
    );

    function automatic logic [6:0] glyph(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {anode_n, seg_n, dp_n} for the current model cycle
    function automatic logic [11:0] model_out();
        int slot = mn % SDIV;
        int idx  = (mn / SDIV) % 4;
        int dig;
        logic [3:0] a = 4'b1111;
        logic [6:0] s;
        logic       dp;
        dig = (idx == 0) ? sh_i : (idx == 1) ? sh_f1 : sh_f2;
        s   = (idx == 3) ? 7'h7F : glyph(dig);
        dp  = (idx == 0) ? 1'b0 : 1'b1;
        if (slot >= BLANK_CYC && !mblink) a = ~(4'b0001 << idx);
        return {a, s, dp};
    endfunction

    // Advance one clock; model follows the rules of flag/capture/blink
    task automatic tick();
        bit r = rst;
        int m = mn;
        int a = integer_data, b = float1_data, c = float2_data;
        @(posedge clk);
        if (r) begin
            mn = 0; sh_i = 0; sh_f1 = 0; sh_f2 = 0; mblink = 1'b0;
        end else begin
            mn = m + 1;
            // flag at m%UDIV == UDIV-1; capture two cycles later
            if (m >= UDIV + 1 && m % UDIV == 1) begin
                sh_i = a; sh_f1 = b; sh_f2 = c;
            end
`ifdef SSEG_OVERRANGE_BLINK_EN
            if (!(sh_i == 5 && sh_f1 == 0 && sh_f2 == 0)) mblink = 1'b0;
            else if (m % UDIV == UDIV - 1) mblink = ~mblink;
`endif
        end
        #1;
    endtask

    // Hold the wanted digits across the two cycles after flag, noise elsewhere
    task automatic drive(int i, int f1, int f2);
        if (mn >= UDIV && (mn % UDIV == 0 || mn % UDIV == 1)) begin
            integer_data = 4'(i); float1_data = 4'(f1); float2_data = 4'(f2);
        end else begin
            integer_data = 4'($urandom_range(0, 15));
            float1_data  = 4'($urandom_range(0, 15));
            float2_data  = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic seek(int phase, int i, int f1, int f2);
        for (int k = 0; k < 4 * SDIV && (mn % (4 * SDIV)) != phase; k++) begin
            drive(i, f1, f2);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if ({flag, anode_n, seg_n, dp_n} !== {1'b0, 4'b1111, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_held: got %b/%b/%b/%b want 0/1111/1111111/1", flag, anode_n, seg_n, dp_n);
        end
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({flag, anode_n, seg_n, dp_n} !== {1'b0, 4'b1111, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_release: got %b/%b/%b/%b want 0/1111/1111111/1", flag, anode_n, seg_n, dp_n);
        end
    endtask

    task automatic test_flag_timing();
        int first = -1, prev = -1, bad_period = 0, width_bad = 0;
        for (int k = 0; k < 2 * UDIV + 100; k++) begin
            drive(1, 2, 3);
            tick();
            if (flag === 1'b1) begin
                if (first < 0) first = mn;
                if (prev >= 0 && mn - prev != UDIV) bad_period++;
                if (prev == mn - 1) width_bad++;
                prev = mn;
            end
            n_cmp++;
            if (flag !== (mn % UDIV == UDIV - 1)) begin
                n_bad++;
                $display("FAIL flag_cycle: n=%0d got %b want %b", mn, flag, (mn % UDIV == UDIV - 1));
            end
        end
        n_cmp++;
        if (first != UDIV - 1) begin
            n_bad++;
            $display("FAIL flag_first: got cycle %0d want %0d", first, UDIV - 1);
        end
        n_cmp++;
        if (bad_period != 0 || width_bad != 0) begin
            n_bad++;
            $display("FAIL flag_period: bad periods %0d wide pulses %0d want 0/0", bad_period, width_bad);
        end
    endtask

    // Run a scenario for a number of cycles comparing every output each cycle
    task automatic test_display(string name, int i, int f1, int f2, int cycles);
        logic [11:0] e;
        for (int k = 0; k < cycles; k++) begin
            drive(i, f1, f2);
            tick();
            e = model_out();
            n_cmp++;
            if (anode_n !== e[11:8] || flag !== (mn % UDIV == UDIV - 1)) begin
                n_bad++;
                $display("FAIL %s_anode: n=%0d got %b flag %b want %b flag %b", name, mn, anode_n, flag, e[11:8], (mn % UDIV == UDIV - 1));
            end
            if (e[11:8] != 4'b1111) begin
                n_cmp++;
                if (seg_n !== e[7:1] || dp_n !== e[0]) begin
                    n_bad++;
                    $display("FAIL %s_seg: n=%0d got %b dp %b want %b dp %b", name, mn, seg_n, dp_n, e[7:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_value_327();
        test_display("v327", 3, 2, 7, UDIV + 20);
        seek(5, 3, 2, 7);
        n_cmp++;
        if ({anode_n, seg_n, dp_n} !== {4'b1110, 7'b0110000, 1'b0}) begin
            n_bad++;
            $display("FAIL d0_327: got %b/%b/%b want 1110/0110000/0", anode_n, seg_n, dp_n);
        end
        seek(15, 3, 2, 7);
        n_cmp++;
        if ({anode_n, seg_n, dp_n} !== {4'b1101, 7'b0100100, 1'b1}) begin
            n_bad++;
            $display("FAIL d1_327: got %b/%b/%b want 1101/0100100/1", anode_n, seg_n, dp_n);
        end
        seek(25, 3, 2, 7);
        n_cmp++;
        if ({anode_n, seg_n, dp_n} !== {4'b1011, 7'b1111000, 1'b1}) begin
            n_bad++;
            $display("FAIL d2_327: got %b/%b/%b want 1011/1111000/1", anode_n, seg_n, dp_n);
        end
        seek(35, 3, 2, 7);
        n_cmp++;
        if ({anode_n, seg_n} !== {4'b0111, 7'h7F}) begin
            n_bad++;
            $display("FAIL d3_blank: got %b/%b want 0111/1111111", anode_n, seg_n);
        end
        seek(1, 3, 2, 7);
        n_cmp++;
        if (anode_n !== 4'b1111) begin
            n_bad++;
            $display("FAIL slot_blank: got %b want 1111", anode_n);
        end
    endtask

    task automatic test_dash();
        test_display("dash", 6, 11, 4, UDIV + 20);
        seek(15, 6, 11, 4);
        n_cmp++;
        if ({anode_n, seg_n} !== {4'b1101, 7'b0111111}) begin
            n_bad++;
            $display("FAIL d1_dash: got %b/%b want 1101/0111111", anode_n, seg_n);
        end
    endtask

    task automatic test_mid_reset();
        seek(25, 6, 11, 4);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({flag, anode_n, seg_n, dp_n} !== {1'b0, 4'b1111, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_reset: got %b/%b/%b/%b want 0/1111/1111111/1", flag, anode_n, seg_n, dp_n);
        end
        rst = 1'b0;
        test_display("restart", 8, 8, 8, 3 * SDIV);
    endtask

    task automatic test_overrange();
        test_display("sat", 5, 0, 0, 3 * UDIV + 50);
        test_display("leave", 4, 9, 0, UDIV + 100);
    endtask

    initial begin
        test_reset();
        test_flag_timing();
        test_value_327();
        test_dash();
        test_mid_reset();
        test_overrange();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sseg_scanner
`default_nettype wire
